alu_core: RTL
=============

# alu_core

Arithmetic/logic stage directly downstream of the accumulator: consumes the accumulator output and the B-register value, executes one operation per accepted command, and holds the 16-bit result and status flags for the bus driver and control sequencer. Single-cycle ops finish in one clock. MUL/DIV/MOD are iterative and take 16 clocks, so the accumulator may be rewritten while they run.

## Interface
- `WIDTH`, 16, datapath width; the iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `alu_start`  in  1  command strobe; accepted only when `alu_busy`=0.
- `alu_op`  in  4  opcode, sampled with `alu_start`.
- `a_in`  in  WIDTH  accumulator output `aout`.
- `b_in`  in  WIDTH  B-register value.
- `alu_busy`  out  1  iterative operation in progress.
- `alu_done`  out  1  one-cycle pulse; `alu_result` and the flags are valid from this cycle on.
- `alu_result`  out  WIDTH  registered result, held until the next completion.
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  out  1 each  registered status flags.
- `div_by_zero`  out  1  last DIV/MOD had `b`=0; cleared by the next accepted start.

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a−b; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 SHL a,1; 7 SHR a,1 (logical); 8 MUL (low 16 bits, unsigned); 9 DIV (unsigned quotient); 10 MOD (unsigned remainder); 11 CMP (a−b, flags only, `alu_result` unchanged); 12–15 illegal.
- Operands are captured into internal registers on the accepting edge. Later changes to `a_in`/`b_in` do not affect the operation in flight.
- FSM states:
  - IDLE: start with a single-cycle op → compute and stay in IDLE. Start with MUL/DIV/MOD and `b`≠0 → RUN with count=0.
  - RUN: one shift-add (MUL) or restoring-subtract (DIV/MOD) step per clock. On count=WIDTH−1, write result and flags, then return to IDLE.
- Flags update only at completion:
  - Z = result==0 (for CMP, computed on the difference).
  - N = result[15].
  - C: ADD carry-out; SUB/CMP borrow (1 when a<b unsigned); SHL a[15]; SHR a[0]; MUL 1 if the upper 16 product bits ≠ 0; otherwise 0.
  - V: signed overflow for ADD/SUB/CMP; otherwise 0.
- Divide by zero completes in one cycle, no RUN state:
  - DIV result 0xFFFF; MOD result a.
  - `div_by_zero`=1, C=1, V=0; Z and N from the result.
- Illegal opcode: `alu_done` pulses; result, flags and `div_by_zero` unchanged.
- `alu_start` while `alu_busy`=1 is ignored, with no queueing.

## Timing
- Reset values: `alu_result`=0, all flags 0, `div_by_zero`=0, `alu_busy`=0, `alu_done`=0, FSM IDLE, counter 0.
- Single-cycle op accepted at edge k: result, flags and `alu_done` are visible after edge k. `alu_done` drops after edge k+1.
- Iterative op accepted at edge k:
  - `alu_busy` is 1 after edge k through edge k+15 and drops after edge k+16.
  - Result, flags and the `alu_done` pulse are visible after edge k+16.
- Back-to-back: a start in the same cycle `alu_done` is high is accepted.
- Reset asserted mid-RUN aborts the operation immediately: outputs return to reset values and no `alu_done` is issued.
- Results are registered, so there is no combinational path from inputs to outputs.

## Structure
- Package `alu_pkg`:
  - opcode localparams (`OP_ADD`…`OP_CMP`);
  - FSM state encoding (`ST_IDLE`, `ST_RUN`);
  - iteration count constant.
- Sub-module `alu_muldiv_seq`:
  - holds the iterative multiplier/divider datapath (partial product / remainder, quotient, counter);
  - controlled by start/op/finish from `alu_core`;
  - single-cycle ops stay in `alu_core`.

## Test plan
- ADD a=0xFFFF, b=0x0001 → result 0x0000, Z=1, C=1, V=0, N=0, `alu_done` one cycle after the start edge.
- SUB a=0x8000, b=0x0001 → 0x7FFF, V=1, C=0, N=0. CMP a=0x0003, b=0x0005 → result unchanged, C=1, N=1.
- MUL a=0x0300, b=0x0100 → 0x0000 with C=1, Z=1. Check `alu_busy` for exactly 16 cycles and that `a_in` changing mid-run does not alter the result.
- DIV a=100, b=7 → 14; MOD a=100, b=7 → 2. DIV a=0x1234, b=0 → 0xFFFF, `div_by_zero`=1, done after 1 cycle.
- Start pulses during `alu_busy` are ignored. A start on the `alu_done` cycle is accepted. Illegal op 0xE → done pulse with result and flags held.
- Assert `rst`=0 at RUN cycle 8 → busy/done/result/flags all 0 immediately. A fresh ADD 2+3 after release gives 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU stage: opcodes, FSM encoding, iteration count,
// and the signed-overflow helper used by ADD/SUB/CMP.
package alu_pkg;

  localparam int ITER_COUNT = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MOD = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Two's-complement overflow from operand and result sign bits. For a
  // subtraction pass the inverted sign of the subtrahend.
  function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                      input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply / restoring-divide datapath. Operands are captured on
// load; each step advances both the shift-add product and the restoring
// quotient/remainder by one bit. Outputs show the values the current step
// produces, so the caller can latch them on the final step's edge.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ITER_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             last,
  output logic [WIDTH-1:0] mul_lo,
  output logic             mul_hi_nz,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dvsr_r;

  logic [2*WIDTH-1:0] prod_nxt_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [WIDTH-1:0]   quo_nxt_s;
  logic               last_s;

  // One shift-add and one restoring-subtract step from the current state.
  always_comb begin
    prod_nxt_s = prod_r;
    rem_nxt_s  = rem_r;
    quo_nxt_s  = quo_r;
    shift_s    = {rem_r, quo_r[WIDTH-1]};
    diff_s     = shift_s - {1'b0, dvsr_r};
    if (mplier_r[0]) begin
      prod_nxt_s = prod_r + mcand_r;
    end else begin
      prod_nxt_s = prod_r;
    end
    // A set top bit means the trial subtraction went negative: restore.
    if (diff_s[WIDTH]) begin
      rem_nxt_s = shift_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt_s = diff_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
    end
  end

  assign last_s    = step && (count_r == CW'(WIDTH - 1));
  assign last      = last_s;
  assign mul_lo    = prod_nxt_s[WIDTH-1:0];
  assign mul_hi_nz = |prod_nxt_s[2*WIDTH-1:WIDTH];
  assign quo       = quo_nxt_s;
  assign rem       = rem_nxt_s;

  // Operand capture on load, then one iteration per step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r  <= {CW{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      dvsr_r   <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r  <= {CW{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a_in};
      mplier_r <= b_in;
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= a_in;
      dvsr_r   <= b_in;
    end else if (step) begin
      count_r  <= last_s ? {CW{1'b0}} : count_r + CW'(1);
      prod_r   <= prod_nxt_s;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      rem_r    <= rem_nxt_s;
      quo_r    <= quo_nxt_s;
    end
  end

endmodule

// File: rtl/alu_core.sv
// ALU stage after the accumulator. Single-cycle ops complete on the accepting
// edge; MUL and non-zero DIV/MOD run WIDTH steps in alu_muldiv_seq. Result and
// flags are registered and held until the next completion.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ITER_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             alu_busy,
  output logic             alu_done,
  output logic [WIDTH-1:0] alu_result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             div_by_zero
);

  logic [0:0]       state_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] result_r;
  logic             z_r, n_r, c_r, v_r, dbz_r, done_r;

  logic [WIDTH:0]   sum_s, dif_s;
  logic [WIDTH-1:0] val_s;
  logic             c_s, v_s, dbz_nxt_s;
  logic             go_run_s, done_s, upd_res_s, upd_flg_s;
  logic             seq_last_s, seq_hi_nz_s;
  logic [WIDTH-1:0] seq_mul_s, seq_quo_s, seq_rem_s;

  assign sum_s = {1'b0, a_in} + {1'b0, b_in};
  assign dif_s = {1'b0, a_in} - {1'b0, b_in};

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .load      (go_run_s),
    .step      (state_r == ST_RUN),
    .a_in      (a_in),
    .b_in      (b_in),
    .last      (seq_last_s),
    .mul_lo    (seq_mul_s),
    .mul_hi_nz (seq_hi_nz_s),
    .quo       (seq_quo_s),
    .rem       (seq_rem_s)
  );

  // Command decode in IDLE and completion of the iterative op in RUN.
  always_comb begin
    go_run_s  = 1'b0;
    done_s    = 1'b0;
    upd_res_s = 1'b0;
    upd_flg_s = 1'b0;
    val_s     = {WIDTH{1'b0}};
    c_s       = 1'b0;
    v_s       = 1'b0;
    dbz_nxt_s = dbz_r;
    if (state_r == ST_IDLE) begin
      if (alu_start) begin
        done_s    = 1'b1;
        upd_res_s = 1'b1;
        upd_flg_s = 1'b1;
        dbz_nxt_s = 1'b0;
        case (alu_op)
          OP_ADD: begin
            val_s = sum_s[WIDTH-1:0];
            c_s   = sum_s[WIDTH];
            v_s   = signed_ovf(a_in[WIDTH-1], b_in[WIDTH-1], sum_s[WIDTH-1]);
          end
          OP_SUB, OP_CMP: begin
            val_s     = dif_s[WIDTH-1:0];
            c_s       = dif_s[WIDTH];
            v_s       = signed_ovf(a_in[WIDTH-1], ~b_in[WIDTH-1], dif_s[WIDTH-1]);
            upd_res_s = (alu_op == OP_SUB);
          end
          OP_AND: val_s = a_in & b_in;
          OP_OR:  val_s = a_in | b_in;
          OP_XOR: val_s = a_in ^ b_in;
          OP_NOT: val_s = ~a_in;
          OP_SHL: begin
            val_s = {a_in[WIDTH-2:0], 1'b0};
            c_s   = a_in[WIDTH-1];
          end
          OP_SHR: begin
            val_s = {1'b0, a_in[WIDTH-1:1]};
            c_s   = a_in[0];
          end
          OP_MUL, OP_DIV, OP_MOD: begin
            if ((alu_op != OP_MUL) && (b_in == {WIDTH{1'b0}})) begin
              // Divide by zero finishes at once with a saturated quotient.
              val_s     = (alu_op == OP_DIV) ? {WIDTH{1'b1}} : a_in;
              c_s       = 1'b1;
              dbz_nxt_s = 1'b1;
            end else begin
              go_run_s  = 1'b1;
              done_s    = 1'b0;
              upd_res_s = 1'b0;
              upd_flg_s = 1'b0;
            end
          end
          default: begin
            // Illegal opcode: acknowledge only, keep all visible state.
            upd_res_s = 1'b0;
            upd_flg_s = 1'b0;
            dbz_nxt_s = dbz_r;
          end
        endcase
      end else begin
        done_s = 1'b0;
      end
    end else begin
      if (seq_last_s) begin
        done_s    = 1'b1;
        upd_res_s = 1'b1;
        upd_flg_s = 1'b1;
        case (op_r)
          OP_MUL: begin
            val_s = seq_mul_s;
            c_s   = seq_hi_nz_s;
          end
          OP_MOD:  val_s = seq_rem_s;
          default: val_s = seq_quo_s;
        endcase
      end else begin
        done_s = 1'b0;
      end
    end
  end

  // FSM, registered result/flags and the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      op_r     <= 4'd0;
      result_r <= {WIDTH{1'b0}};
      z_r      <= 1'b0;
      n_r      <= 1'b0;
      c_r      <= 1'b0;
      v_r      <= 1'b0;
      dbz_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      if (go_run_s) begin
        state_r <= ST_RUN;
        op_r    <= alu_op;
      end else if (seq_last_s) begin
        state_r <= ST_IDLE;
      end
      if (upd_res_s) begin
        result_r <= val_s;
      end
      if (upd_flg_s) begin
        z_r <= (val_s == {WIDTH{1'b0}});
        n_r <= val_s[WIDTH-1];
        c_r <= c_s;
        v_r <= v_s;
      end
      dbz_r  <= dbz_nxt_s;
      done_r <= done_s;
    end
  end

  assign alu_busy    = (state_r == ST_RUN);
  assign alu_done    = done_r;
  assign alu_result  = result_r;
  assign flag_z      = z_r;
  assign flag_n      = n_r;
  assign flag_c      = c_r;
  assign flag_v      = v_r;
  assign div_by_zero = dbz_r;

endmodule
